// File: rtl/ut_pkg.sv
// Shared ultrasound definitions: correlator window, offset width and TX FSM states.
package ut_pkg;

    localparam int unsigned WINDOW   = 400;
    localparam int unsigned OFFSET_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        BURST,
        DAMP
    } tx_state_t;

endpackage

// File: rtl/tx_burst_if.sv
// Control/status bundle between the sequencer and the transmit burst generator.
interface tx_burst_if;
    import ut_pkg::*;

    logic [OFFSET_W-1:0] offset;
    logic                start;
    logic [7:0]          n_cycles;
    logic                busy;
    logic                drv_p;
    logic                drv_n;
    logic                damp;
    logic                t0;
    logic                done;

    modport master (
        output offset, start, n_cycles,
        input  busy, drv_p, drv_n, damp, t0, done
    );

    modport slave (
        input  offset, start, n_cycles,
        output busy, drv_p, drv_n, damp, t0, done
    );

endinterface

// File: rtl/tx_phase_gen.sv
// H-bridge leg decode from the tone phase, with dead time and registered outputs.
module tx_phase_gen #(
    parameter int unsigned PERIOD = 40,
    parameter int unsigned DEAD   = 2,
    parameter int unsigned PH_W   = $clog2(PERIOD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [PH_W-1:0] ph,
    output logic            drv_p,
    output logic            drv_n
);
    import ut_pkg::*;

    localparam logic [PH_W-1:0] P_LO = PH_W'(DEAD);
    localparam logic [PH_W-1:0] P_HI = PH_W'(PERIOD / 2 - 1);
    localparam logic [PH_W-1:0] N_LO = PH_W'(PERIOD / 2 + DEAD);

    logic p_raw, n_raw;
    logic drv_p_q, drv_n_q;

    // Dead-time window decode for each leg of the half-period.
    always_comb begin
        p_raw = en && (ph >= P_LO) && (ph <= P_HI);
        n_raw = en && (ph >= N_LO);
    end

    // Negative leg is masked by the positive one so the bridge can never be shorted.
    always_ff @(posedge clk) begin
        if (rst) begin
            drv_p_q <= 1'b0;
            drv_n_q <= 1'b0;
        end else begin
            drv_p_q <= p_raw;
            drv_n_q <= n_raw & ~p_raw;
        end
    end

    assign drv_p = drv_p_q;
    assign drv_n = drv_n_q;

endmodule

// File: rtl/tx_burst.sv
// Transmit burst generator locked to the correlator sample offset.
// Optional active damping after the burst is enabled by defining TX_BURST_DAMP_EN.
module tx_burst #(
    parameter int unsigned WINDOW   = ut_pkg::WINDOW,
    parameter int unsigned PERIOD   = 40,
    parameter int unsigned DEAD     = 2,
    parameter int unsigned DAMP_LEN = 80
) (
    input logic       clk,
    input logic       rst,
    tx_burst_if.slave bus
);
    import ut_pkg::*;

    localparam int unsigned PH_W   = $clog2(PERIOD);
    localparam int unsigned DAMP_W = (DAMP_LEN > 1) ? $clog2(DAMP_LEN) : 1;
    localparam logic [OFFSET_W-1:0] LAST_OFF = OFFSET_W'(WINDOW - 1);
    localparam logic [PH_W-1:0]     LAST_PH  = PH_W'(PERIOD - 1);

`ifdef TX_BURST_DAMP_EN
    localparam tx_state_t TAIL = DAMP;
`else
    localparam tx_state_t TAIL = IDLE;
`endif

    tx_state_t         state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DAMP_W-1:0] dcnt_q, dcnt_d;
    logic              busy_q, busy_d;
    logic              damp_q, damp_d;
    logic              t0_q, t0_d;
    logic              done_q, done_d;

    // Next state for the following offset; outputs are precomputed so they line up
    // with the offset they belong to.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d   = bus.n_cycles;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (bus.offset == LAST_OFF) begin
                    ph_d    = '0;
                    state_d = (cnt_q == 8'd0) ? TAIL : BURST;
                end
            end
            BURST: begin
                if (ph_q == LAST_PH) begin
                    ph_d  = '0;
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = TAIL;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            DAMP: begin
                if (dcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_d == DAMP) && (state_q != DAMP)) begin
            dcnt_d = DAMP_W'(DAMP_LEN - 1);
        end

        busy_d = (state_d != IDLE);
        t0_d   = (state_d == BURST) && (state_q != BURST);
        done_d = (state_d == IDLE) && (state_q != IDLE);
`ifdef TX_BURST_DAMP_EN
        damp_d = (state_d == DAMP);
`else
        damp_d = 1'b0;
`endif
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            damp_q  <= 1'b0;
            t0_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            busy_q  <= busy_d;
            damp_q  <= damp_d;
            t0_q    <= t0_d;
            done_q  <= done_d;
        end
    end

    logic drv_p, drv_n;

    tx_phase_gen #(
        .PERIOD (PERIOD),
        .DEAD   (DEAD),
        .PH_W   (PH_W)
    ) u_phase_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (state_d == BURST),
        .ph    (ph_d),
        .drv_p (drv_p),
        .drv_n (drv_n)
    );

    assign bus.busy  = busy_q;
    assign bus.damp  = damp_q;
    assign bus.t0    = t0_q;
    assign bus.done  = done_q;
    assign bus.drv_p = drv_p;
    assign bus.drv_n = drv_n;

endmodule

// File: tb/tb_tx_burst.sv
// Directed bench for tx_burst; expected outputs come from burst position arithmetic.
module tb_tx_burst;

    localparam int WINDOW = 400;
    localparam int PERIOD = 40;
    localparam int DEAD   = 2;
`ifdef TX_BURST_DAMP_EN
    localparam int DL = 80;
`else
    localparam int DL = 0;
`endif

    logic clk;
    logic rst;

    tx_burst_if bus ();

    tx_burst u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side burst bookkeeping: r counts cycles since the accepted start.
    bit m_act = 1'b0;
    int m_r   = 0;
    int m_d   = 0;
    int m_n   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running correlator offset.
    initial begin
        bus.offset = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.offset = (bus.offset == 9'(WINDOW - 1)) ? 9'd0 : bus.offset + 9'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_rdone();
        return m_d + m_n * PERIOD + DL;
    endfunction

    // {busy, t0, drv_p, drv_n, damp, done} for the current cycle.
    function automatic logic [5:0] expected();
        int  rb, bl, rd, ph;
        logic b, t, p, n, dm, dn;
        if (!m_act) return 6'd0;
        bl = m_n * PERIOD;
        rd = m_rdone();
        rb = m_r - m_d;
        ph = (rb >= 0) ? rb % PERIOD : 0;
        b  = (m_r < rd);
        t  = (m_n != 0) && (rb == 0);
        p  = (rb >= 0) && (rb < bl) && (ph >= DEAD) && (ph < PERIOD / 2);
        n  = (rb >= 0) && (rb < bl) && (ph >= PERIOD / 2 + DEAD);
        dm = (rb >= bl) && (rb < bl + DL);
        dn = (m_r == rd);
        return {b, t, p, n, dm, dn};
    endfunction

    task automatic model_update();
        int off;
        off = int'(bus.offset);
        if (rst) begin
            m_act = 1'b0;
        end else if (bus.start && (!m_act || (m_r == m_rdone()))) begin
            m_act = 1'b1;
            m_r   = 1;
            m_d   = (off == WINDOW - 1) ? WINDOW + 1 : WINDOW - off;
            m_n   = int'(bus.n_cycles);
        end else if (m_act) begin
            if (m_r == m_rdone()) m_act = 1'b0;
            else m_r++;
        end
    endtask

    // Check the current cycle, advance the model, then move past the next edge.
    task automatic step();
        logic [5:0] obs_v;
        @(negedge clk);
        obs_v = {bus.busy, bus.t0, bus.drv_p, bus.drv_n, bus.damp, bus.done};
        check_eq($sformatf("outs@off%0d", bus.offset), 32'(obs_v), 32'(expected()));
        check_eq("no_overlap", 32'(bus.drv_p & bus.drv_n), 32'd0);
        model_update();
        @(posedge clk);
        #2;
    endtask

    task automatic run_to_off(input int k);
        int guard = 0;
        while ((int'(bus.offset) != k) && (guard < WINDOW + 2)) begin
            step();
            guard++;
        end
    endtask

    task automatic run_to_done();
        int guard = 0;
        while (!(m_act && (m_r == m_rdone())) && (guard < 12000)) begin
            step();
            guard++;
        end
    endtask

    task automatic fire(input int n);
        bus.start    = 1'b1;
        bus.n_cycles = 8'(n);
        step();
        bus.start    = 1'b0;
        bus.n_cycles = 8'hAA;
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.n_cycles = 8'd0;
        repeat (2) @(posedge clk);
        #2;
        repeat (3) step();
        rst = 1'b0;

        // Basic burst, a start while busy, then a new start on the done cycle.
        run_to_off(150);
        fire(3);
        repeat (10) step();
        bus.start    = 1'b1;
        bus.n_cycles = 8'd9;
        step();
        bus.start = 1'b0;
        run_to_done();
        fire(2);
        run_to_done();
        repeat (3) step();

        // Long burst across the offset wrap.
        run_to_off(10);
        fire(25);
        run_to_done();
        step();

        // Start on the last offset waits a full window.
        run_to_off(399);
        fire(1);
        run_to_done();
        step();

        // Zero-length burst.
        run_to_off(200);
        fire(0);
        run_to_done();
        step();

        // Reset mid-burst, then a start five cycles later.
        run_to_off(150);
        fire(3);
        run_to_off(30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        fire(1);
        run_to_done();
        step();

        // Random starts, lengths and occasional resets.
        repeat (6000) begin
            bus.start    = ($urandom_range(0, 47) == 0);
            bus.n_cycles = 8'($urandom_range(0, 4));
            rst          = ($urandom_range(0, 1999) == 0);
            step();
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
